// File: rtl/coinc_pkg.sv
// Shared types and pair-ordering helpers for the coincidence detector and its readout.
// Pair k enumerates channel pairs (i,j) with i<j, j varying fastest.
package coinc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DRAIN
    } rdout_state_t;

    function automatic int npairs(input int nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

    // Rows before i hold (nchan-1)+(nchan-2)+...; within row i, j starts at i+1.
    function automatic int pair_index(input int i, input int j, input int nchan);
        return i * nchan - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pair_accumulator.sv
// One pair's window accumulator: i_clear snapshots the count and zeroes the total; i_acc_en adds the modular delta.
// Latency 1 cycle; no backpressure. COINC_ACC_SATURATE_EN selects saturating accumulate plus a sticky o_sat.
module pair_accumulator
    import coinc_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int NACC  = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_clear,
    input  logic             i_acc_en,
    input  logic [NBITS-1:0] i_count,
    output logic [NACC-1:0]  o_acc
`ifdef COINC_ACC_SATURATE_EN
    ,
    output logic             o_sat
`endif
);

    localparam int SUMW = NACC + 1;

    logic [NBITS-1:0] r_prev;
    logic [NACC-1:0]  r_acc;
    logic [NBITS-1:0] w_delta;

    // Subtraction at NBITS width gives the correct step across a counter wrap.
    assign w_delta = i_count - r_prev;
    assign o_acc   = r_acc;

`ifdef COINC_ACC_SATURATE_EN
    logic            r_sat;
    logic [SUMW-1:0] w_sum;

    assign w_sum = {1'b0, r_acc} + SUMW'(w_delta);
    assign o_sat = r_sat;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_prev <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else if (i_clear) begin
            r_prev <= i_count;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else if (i_acc_en) begin
            r_prev <= i_count;
            if (w_sum[NACC]) begin
                r_acc <= '1;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[NACC-1:0];
            end
        end
    end
`else
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_prev <= '0;
            r_acc  <= '0;
        end else if (i_clear) begin
            r_prev <= i_count;
            r_acc  <= '0;
        end else if (i_acc_en) begin
            r_prev <= i_count;
            r_acc  <= r_acc + NACC'(w_delta);
        end
    end
`endif

endmodule

// File: rtl/coinc_window_readout.sv
// Gates the detector's wrapping pair counts over WindowLen cycles, then streams one total per pair (valid/ready).
// Latency: first Out_Valid WindowLen edges after the Start-sampling edge; DRAIN holds words while Out_Ready=0.
// Optional macro COINC_ACC_SATURATE_EN: saturating accumulators and an extra Out_Sat output.
module coinc_window_readout
    import coinc_pkg::*;
#(
    parameter  int NCHAN  = 4,
    parameter  int NBITS  = 4,
    parameter  int NACC   = 16,
    parameter  int NWIN   = 16,
    localparam int NPAIRS = npairs(NCHAN),
    localparam int IDXW   = idx_width(NPAIRS)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NPAIRS*NBITS-1:0] Counts,
    input  logic [NWIN-1:0]         WindowLen,
    input  logic                    Start,
    input  logic                    Out_Ready,
    output logic                    Out_Valid,
    output logic [NACC-1:0]         Out_Data,
    output logic [IDXW-1:0]         Out_Index,
    output logic                    Out_Last,
    output logic                    Busy,
    output logic                    Done
`ifdef COINC_ACC_SATURATE_EN
    ,
    output logic                    Out_Sat
`endif
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPAIRS - 1);

    rdout_state_t    r_state;
    logic [NWIN-1:0] r_remaining;
    logic [IDXW-1:0] r_idx;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic            r_done;

    logic            w_clear;
    logic            w_acc_en;
    logic [NACC-1:0] w_acc [NPAIRS];

    assign w_clear  = (r_state == IDLE) && Start;
    assign w_acc_en = (r_state == COUNT);

`ifdef COINC_ACC_SATURATE_EN
    logic w_sat [NPAIRS];
`endif

    for (genvar k = 0; k < NPAIRS; k++) begin : g_pair
        pair_accumulator #(
            .NBITS (NBITS),
            .NACC  (NACC)
        ) u_acc (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .i_clear  (w_clear),
            .i_acc_en (w_acc_en),
            .i_count  (Counts[k*NBITS +: NBITS]),
            .o_acc    (w_acc[k])
`ifdef COINC_ACC_SATURATE_EN
            ,
            .o_sat    (w_sat[k])
`endif
        );
    end

    // Accumulators are frozen in DRAIN, so a plain mux keeps stalled words stable.
    assign Out_Valid = r_valid;
    assign Out_Data  = r_valid ? w_acc[r_idx] : '0;
    assign Out_Index = r_idx;
    assign Out_Last  = r_last;
    assign Busy      = r_busy;
    assign Done      = r_done;
`ifdef COINC_ACC_SATURATE_EN
    assign Out_Sat   = r_valid & w_sat[r_idx];
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_remaining <= WindowLen;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        if (WindowLen == '0) begin
                            r_state <= DRAIN;
                            r_valid <= 1'b1;
                            r_last  <= (LAST_IDX == '0);
                        end else begin
                            r_state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    r_remaining <= r_remaining - NWIN'(1);
                    // The sample taken on this edge is the last of the window.
                    if (r_remaining == NWIN'(1)) begin
                        r_state <= DRAIN;
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                    end
                end
                DRAIN: begin
                    if (Out_Ready) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx  <= r_idx + IDXW'(1);
                            r_last <= ((r_idx + IDXW'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coinc_window_readout.sv
// Randomised bench: unwrapped integer pair counters are the reference; each window's expected total is the
// counter difference between the Start-sampling edge and the last sampled edge.
module tb_coinc_window_readout;

    localparam int NCHAN = 4;
    localparam int NBITS = 4;
    localparam int NACC  = 16;
    localparam int NWIN  = 16;
    localparam int NP    = NCHAN * (NCHAN - 1) / 2;

    logic                  Clk = 1'b0;
    logic                  Rst_n;
    logic [NP*NBITS-1:0]   Counts;
    logic [NWIN-1:0]       WindowLen;
    logic                  Start;
    logic                  Out_Ready;

    logic                  Out_Valid, Out_Last, Busy, Done;
    logic [NACC-1:0]       Out_Data;
    logic [2:0]            Out_Index;
    logic                  s_valid, s_last, s_busy, s_done;
    logic [3:0]            s_data;
    logic [2:0]            s_index;
`ifdef COINC_ACC_SATURATE_EN
    logic                  Out_Sat, s_sat;
`endif

    int ucnt [NP];
    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    coinc_window_readout #(.NCHAN(NCHAN), .NBITS(NBITS), .NACC(NACC), .NWIN(NWIN)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Counts(Counts), .WindowLen(WindowLen), .Start(Start),
        .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Index(Out_Index),
        .Out_Last(Out_Last), .Busy(Busy), .Done(Done)
`ifdef COINC_ACC_SATURATE_EN
        , .Out_Sat(Out_Sat)
`endif
    );

    // Narrow-accumulator instance sharing all inputs, used to observe overflow behaviour.
    coinc_window_readout #(.NCHAN(NCHAN), .NBITS(NBITS), .NACC(4), .NWIN(NWIN)) u_dut_n4 (
        .Clk(Clk), .Rst_n(Rst_n), .Counts(Counts), .WindowLen(WindowLen), .Start(Start),
        .Out_Ready(Out_Ready), .Out_Valid(s_valid), .Out_Data(s_data), .Out_Index(s_index),
        .Out_Last(s_last), .Busy(s_busy), .Done(s_done)
`ifdef COINC_ACC_SATURATE_EN
        , .Out_Sat(s_sat)
`endif
    );

    task automatic drive_counts();
        for (int k = 0; k < NP; k++) Counts[k*NBITS +: NBITS] = NBITS'(ucnt[k]);
    endtask

    // mode 1: pair 2 fires on window cycles 2,5,7; mode 2: pair 0 every cycle; otherwise random per pair.
    task automatic step_counts(input int mode, input int c);
        for (int k = 0; k < NP; k++) begin
            case (mode)
                1: if (k == 2 && (c == 2 || c == 5 || c == 7)) ucnt[k] = ucnt[k] + 1;
                2: if (k == 0) ucnt[k] = ucnt[k] + 1;
                default: ucnt[k] = ucnt[k] + int'($urandom_range(0, 1));
            endcase
        end
        drive_counts();
    endtask

    // Entered and left at a falling edge; leaves on the Done cycle so the next call starts back-to-back.
    task automatic run_window(input string name, input int w, input int inc_mode, input int rdy_mode, input bit poke);
        int u0 [NP];
        int tot [NP];
        int idx, cyc, exp_small;
        bit rdy, exp_sat;
        WindowLen = NWIN'(w);
        Start     = 1'b1;
        for (int k = 0; k < NP; k++) u0[k] = ucnt[k];
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || Out_Valid !== (w == 0)) begin
            failures++;
            $display("FAIL %s start: busy=%b done=%b valid=%b, want busy=1 done=0 valid=%0d", name, Busy, Done, Out_Valid, w == 0);
        end
        for (int c = 1; c <= w; c++) begin
            Start = poke && (c == 1);
            if (poke && c == 1) WindowLen = NWIN'(3);
            step_counts(inc_mode, c);
            @(posedge Clk); @(negedge Clk);
            checks++;
            if (Out_Valid !== (c == w) || Busy !== 1'b1) begin
                failures++;
                $display("FAIL %s latency c=%0d: valid=%b busy=%b, want valid=%0d busy=1", name, c, Out_Valid, Busy, c == w);
            end
        end
        Start = 1'b0;
        for (int k = 0; k < NP; k++) tot[k] = ucnt[k] - u0[k];

        idx = 0;
        cyc = 0;
        while (idx < NP && cyc < 100) begin
            checks++;
            if (Out_Valid !== 1'b1 || Out_Index !== 3'(idx) || Out_Data !== NACC'(tot[idx]) ||
                Out_Last !== (idx == NP - 1) || Busy !== 1'b1 || Done !== 1'b0) begin
                failures++;
                $display("FAIL %s word cyc=%0d: v=%b idx=%0d data=%0d last=%b busy=%b done=%b, want v=1 idx=%0d data=%0d last=%0d busy=1 done=0",
                         name, cyc, Out_Valid, Out_Index, Out_Data, Out_Last, Busy, Done, idx, tot[idx], idx == NP - 1);
            end
`ifdef COINC_ACC_SATURATE_EN
            exp_small = (tot[idx] > 15) ? 15 : tot[idx];
            exp_sat   = (tot[idx] > 15);
            checks++;
            if (Out_Sat !== 1'b0 || s_sat !== exp_sat) begin
                failures++;
                $display("FAIL %s sat idx=%0d: wide=%b narrow=%b, want wide=0 narrow=%b", name, idx, Out_Sat, s_sat, exp_sat);
            end
`else
            exp_small = tot[idx] % 16;
            exp_sat   = 1'b0;
`endif
            checks++;
            if (s_valid !== 1'b1 || s_index !== 3'(idx) || s_data !== 4'(exp_small)) begin
                failures++;
                $display("FAIL %s narrow idx=%0d: v=%b idx=%0d data=%0d, want v=1 idx=%0d data=%0d", name, idx, s_valid, s_index, s_data, idx, exp_small);
            end
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            Out_Ready = rdy;
            Start     = poke && (cyc == 0);
            if (Start) WindowLen = NWIN'(5);
            step_counts(0, 0);
            @(posedge Clk); @(negedge Clk);
            if (rdy) idx++;
            cyc++;
        end
        Start = 1'b0;
        checks++;
        if (idx != NP) begin
            failures++;
            $display("FAIL %s drain timeout: handshakes=%0d, want %0d", name, idx, NP);
        end
        checks++;
        if (Done !== 1'b1 || s_done !== 1'b1 || Out_Valid !== 1'b0 || Busy !== 1'b0 || Out_Last !== 1'b0 || Out_Data !== '0) begin
            failures++;
            $display("FAIL %s done: done=%b narrow_done=%b valid=%b busy=%b last=%b data=%0d, want 1 1 0 0 0 0",
                     name, Done, s_done, Out_Valid, Busy, Out_Last, Out_Data);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b0; Out_Ready = 1'b0; WindowLen = '0;
        for (int k = 0; k < NP; k++) ucnt[k] = int'($urandom_range(0, 15));
        drive_counts();
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || Out_Data !== '0 || Out_Index !== 3'd0 || Out_Last !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset: valid=%b data=%0d idx=%0d last=%b busy=%b done=%b, want all 0", Out_Valid, Out_Data, Out_Index, Out_Last, Busy, Done);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); @(negedge Clk);
        checks++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset idle: valid=%b busy=%b done=%b, want 0 0 0", Out_Valid, Busy, Done);
        end
    endtask

    task automatic test_basic();
        run_window("basic", 10, 1, 0, 1'b0);
    endtask

    task automatic test_wrap();
        ucnt[0] = ucnt[0] + ((14 - ucnt[0]) & 15);
        drive_counts();
        run_window("wrap", 5, 2, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_window("stall", 6, 0, 1, 1'b0);
    endtask

    task automatic test_zero_window();
        run_window("zero_window", 0, 0, 0, 1'b1);
    endtask

    task automatic test_start_busy();
        run_window("start_busy", 8, 0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_window("b2b_a", 3, 0, 0, 1'b0);
        run_window("b2b_b", 1, 0, 2, 1'b0);
    endtask

    task automatic test_reset_abort();
        WindowLen = NWIN'(10);
        Start     = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step_counts(0, c);
            @(posedge Clk); @(negedge Clk);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0 || Done !== 1'b0 || Out_Data !== '0 || Out_Index !== 3'd0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort: busy=%b valid=%b done=%b data=%0d idx=%0d, want all 0", Busy, Out_Valid, Done, Out_Data, Out_Index);
        end
        @(posedge Clk); @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Out_Valid !== 1'b0) begin
            failures++;
            $display("FAIL abort release: busy=%b done=%b valid=%b, want 0 0 0", Busy, Done, Out_Valid);
        end
        run_window("after_abort", 2, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_window("random", int'($urandom_range(0, 12)), 0, 2, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_saturate();
        run_window("saturate", 20, 2, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_window();
        test_start_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
